// File: rtl/alu_control_unit.sv
// alu_control_unit
// Multi-cycle sequencer for an 8-bit ALU / 4-entry register-file datapath.
// Each instruction passes through FETCH -> DECODE -> EXECUTE -> WRITEBACK.
// Jumps and NOP retire at the end of EXECUTE. HLT parks the unit in HALT until reset.
// The datapath controls are decoded combinationally from the instruction register,
// so they hold steady from DECODE through WRITEBACK.
// Optional feature: define ALU_CTRL_RETIRE_CNT_EN to add the 16-bit `retired`
// output, which counts completed instructions.
module alu_control_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_c,
    input  logic        alu_v,
    output logic [7:0]  pc,
    output logic [3:0]  alu_sel,
    output logic [1:0]  rf_ra,
    output logic [1:0]  rf_rb,
    output logic [1:0]  rf_wa,
    output logic        rf_we,
    output logic        wb_sel,
    output logic [7:0]  imm,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c,
    output logic        flag_v,
    output logic        halted
`ifdef ALU_CTRL_RETIRE_CNT_EN
    ,
    output logic [15:0] retired
`endif
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    localparam logic [3:0] OP_LAST_WR  = 4'h8;  // INC: the last ALU op that writes rd
    localparam logic [3:0] OP_CMP      = 4'h9;
    localparam logic [3:0] OP_LDI      = 4'hA;
    localparam logic [3:0] OP_JMP      = 4'hB;
    localparam logic [3:0] OP_JZ       = 4'hC;
    localparam logic [3:0] OP_JC       = 4'hD;
    localparam logic [3:0] OP_NOP      = 4'hE;
    localparam logic [3:0] OP_HLT      = 4'hF;

    state_t      state, state_nx;
    logic [7:0]  pc_nx;
    logic [15:0] ir, ir_nx;
    flags_t      flags, flags_nx;
    logic        halted_nx;

    logic [3:0]  opcode;
    logic        is_alu_op;
    logic        writes_rf;

    // Instruction fields, decoded straight from IR.
    assign opcode    = ir[15:12];
    assign is_alu_op = (opcode <= OP_CMP);
    assign writes_rf = (opcode <= OP_LAST_WR) || (opcode == OP_LDI);

    assign alu_sel = is_alu_op ? opcode : 4'h0;
    assign rf_ra   = ir[11:10];
    assign rf_rb   = ir[9:8];
    assign rf_wa   = ir[11:10];
    assign imm     = ir[7:0];
    assign wb_sel  = (opcode == OP_LDI);

    assign flag_z  = flags.z;
    assign flag_n  = flags.n;
    assign flag_c  = flags.c;
    assign flag_v  = flags.v;

    // Next-state, next-register and write-enable logic for the instruction sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can leave one unassigned and infer a latch.
        state_nx  = state;
        pc_nx     = pc;
        ir_nx     = ir;
        flags_nx  = flags;
        halted_nx = halted;
        rf_we     = 1'b0;

        case (state)
            S_FETCH: begin
                ir_nx    = instr;
                pc_nx    = pc + 8'd1;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                state_nx = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (opcode)
                    OP_LDI: state_nx = S_WRITEBACK;
                    OP_JMP: begin
                        pc_nx    = imm;
                        state_nx = S_FETCH;
                    end
                    OP_JZ: begin
                        if (flags.z) pc_nx = imm;
                        state_nx = S_FETCH;
                    end
                    OP_JC: begin
                        if (flags.c) pc_nx = imm;
                        state_nx = S_FETCH;
                    end
                    OP_NOP: state_nx = S_FETCH;
                    OP_HLT: begin
                        halted_nx = 1'b1;
                        state_nx  = S_HALT;
                    end
                    default: begin
                        // ALU ops 0x0-0x9: capture the live flags once per instruction.
                        flags_nx = {alu_z, alu_n, alu_c, alu_v};
                        state_nx = S_WRITEBACK;
                    end
                endcase
            end
            S_WRITEBACK: begin
                rf_we    = writes_rf;
                state_nx = S_FETCH;
            end
            S_HALT: begin
                state_nx = S_HALT;
            end
            default: begin
                state_nx = S_FETCH;
            end
        endcase
    end

    // State, program counter, instruction and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FETCH;
            pc     <= 8'h00;
            ir     <= 16'h0000;
            flags  <= '0;
            halted <= 1'b0;
        end else begin
            // NOTE: clocked state is updated with non-blocking assignments only, so every register sees pre-edge values.
            state  <= state_nx;
            pc     <= pc_nx;
            ir     <= ir_nx;
            flags  <= flags_nx;
            halted <= halted_nx;
        end
    end

`ifdef ALU_CTRL_RETIRE_CNT_EN
    logic        retire;
    logic [15:0] retired_q;

    // An instruction completes when EXECUTE or WRITEBACK hands back to FETCH, or enters HALT.
    assign retire = ((state == S_EXECUTE) || (state == S_WRITEBACK)) &&
                    ((state_nx == S_FETCH) || (state_nx == S_HALT));

    // Retired-instruction counter, wraps modulo 2^16.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_q <= 16'h0000;
        end else if (retire) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    assign retired = retired_q;
`endif

endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit
// The bench provides the program memory, a 4-entry register file and an ALU
// around the control unit. An instruction-level reference model predicts the
// architectural state (pc, flags, registers, halted, retired count) after
// every instruction. Vectors come from a decode table, hand-written sequences
// and randomized programs.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        alu_z, alu_n, alu_c, alu_v;
    logic [7:0]  pc;
    logic [3:0]  alu_sel;
    logic [1:0]  rf_ra, rf_rb, rf_wa;
    logic        rf_we, wb_sel;
    logic [7:0]  imm;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        halted;
`ifdef ALU_CTRL_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    alu_control_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .instr  (instr),
        .alu_z  (alu_z),
        .alu_n  (alu_n),
        .alu_c  (alu_c),
        .alu_v  (alu_v),
        .pc     (pc),
        .alu_sel(alu_sel),
        .rf_ra  (rf_ra),
        .rf_rb  (rf_rb),
        .rf_wa  (rf_wa),
        .rf_we  (rf_we),
        .wb_sel (wb_sel),
        .imm    (imm),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c),
        .flag_v (flag_v),
        .halted (halted)
`ifdef ALU_CTRL_RETIRE_CNT_EN
        ,
        .retired(retired)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- environment: program memory, register file, ALU ----------------
    logic [15:0] mem [256];
    logic [7:0]  rf [4];
    logic [7:0]  rf_preset [4];
    logic        rf_load = 1'b0;
    logic [7:0]  alu_res;

    assign instr = mem[pc];

    // ALU semantics: returns {result, z, n, c, v}.
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            4'h1, 4'h9: begin r = a - b; c = (a < b); v = (a[7] != b[7]) && (r[7] != a[7]); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~a;
            4'h6: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'h7: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'h8: begin r = a + 8'd1; c = (a == 8'hFF); v = (a == 8'h7F); end
            default: r = 8'h00;
        endcase
        return {r, (r == 8'h00), r[7], c, v};
    endfunction

    always_comb {alu_res, alu_z, alu_n, alu_c, alu_v} = alu_f(alu_sel, rf[rf_ra], rf[rf_rb]);

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 4; i++) rf[i] <= rf_preset[i];
        end else if (rf_we) begin
            rf[rf_wa] <= wb_sel ? imm : alu_res;
        end
    end

    // ---------------- instruction-level reference model ----------------
    logic [7:0] m_pc;
    logic [3:0] m_fl;       // {z, n, c, v}
    logic [7:0] m_rf [4];
    logic       m_halted;
    int         m_retired;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Executes the instruction at m_pc; returns its cycle count and whether it writes a register.
    task automatic m_step(output int lat, output bit we);
        logic [15:0] ins;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [11:0] r;
        ins = mem[m_pc];
        op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8];
        m_pc = m_pc + 8'd1;
        lat = 3; we = 1'b0;
        m_retired++;
        if (op <= 4'h9) begin
            r = alu_f(op, m_rf[rd], m_rf[rs]);
            m_fl = r[3:0];
            lat = 4;
            if (op != 4'h9) begin m_rf[rd] = r[11:4]; we = 1'b1; end
        end else begin
            case (op)
                4'hA: begin m_rf[rd] = ins[7:0]; lat = 4; we = 1'b1; end
                4'hB: m_pc = ins[7:0];
                4'hC: if (m_fl[3]) m_pc = ins[7:0];
                4'hD: if (m_fl[1]) m_pc = ins[7:0];
                4'hF: m_halted = 1'b1;
                default: ;
            endcase
        end
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after reset release.
    task automatic do_reset(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] r3);
        rst_n = 1'b0;
        rf_preset[0] = r0; rf_preset[1] = r1; rf_preset[2] = r2; rf_preset[3] = r3;
        rf_load = 1'b1;
        @(posedge clk);
        #1 rf_load = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 8'h00; m_fl = 4'h0; m_halted = 1'b0; m_retired = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = rf_preset[i];
    endtask

    // Runs one instruction on the DUT (starting at a FETCH falling edge) and compares with the model.
    task automatic run_instr(input string tag);
        int         lat, we_cnt, we_pos;
        bit         we;
        logic [3:0] op;
        logic [1:0] rd;
        logic [2:0] we_ctl;
        op = mem[m_pc][15:12];
        rd = mem[m_pc][11:10];
        m_step(lat, we);
        we_cnt = 0; we_pos = -1; we_ctl = 3'b000;
        for (int k = 0; k < lat; k++) begin
            if (rf_we === 1'b1) begin
                we_cnt++; we_pos = k; we_ctl = {wb_sel, rf_wa};
            end
            @(posedge clk);
            @(negedge clk);
        end
        check({tag, " pc"}, pc, m_pc);
        check({tag, " flags"}, {flag_z, flag_n, flag_c, flag_v}, m_fl);
        check({tag, " regs"}, {rf[0], rf[1], rf[2], rf[3]}, {m_rf[0], m_rf[1], m_rf[2], m_rf[3]});
        check({tag, " halted"}, halted, m_halted);
        check({tag, " rf_we count"}, we_cnt, we ? 1 : 0);
        check({tag, " rf_we cycle"}, we_pos, we ? lat - 1 : -1);
        check({tag, " wb_sel/rf_wa"}, we_ctl, we ? {(op == 4'hA), rd} : 3'b000);
`ifdef ALU_CTRL_RETIRE_CNT_EN
        check({tag, " retired"}, retired, m_retired[15:0]);
`endif
    endtask

    // ---------------- decode / latency table ----------------
    typedef struct {
        logic [15:0] ins;
        logic [3:0]  alu_sel;
        logic        wb_sel;
        int          cyc;     // cycles from reset release until halted (instruction + following HLT)
        logic [7:0]  pc;      // pc once halted
    } vec_t;

    vec_t vecs [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad_pc, bad_we, bad_halt;
        logic [3:0]  op;
        logic [31:0] r;

        vecs[0] = '{16'h0600, 4'h0, 1'b0, 7, 8'h02};  // ADD r1,r2
        vecs[1] = '{16'h1600, 4'h1, 1'b0, 7, 8'h02};  // SUB r1,r2
        vecs[2] = '{16'h7C00, 4'h7, 1'b0, 7, 8'h02};  // SHR r3,r0
        vecs[3] = '{16'h9900, 4'h9, 1'b0, 7, 8'h02};  // CMP r2,r1
        vecs[4] = '{16'hA8A5, 4'h0, 1'b1, 7, 8'h02};  // LDI r2,0xA5
        vecs[5] = '{16'hB030, 4'h0, 1'b0, 6, 8'h31};  // JMP 0x30
        vecs[6] = '{16'hC030, 4'h0, 1'b0, 6, 8'h02};  // JZ 0x30, flags clear
        vecs[7] = '{16'hD030, 4'h0, 1'b0, 6, 8'h02};  // JC 0x30, flags clear
        vecs[8] = '{16'hE000, 4'h0, 1'b0, 6, 8'h02};  // NOP
        vecs[9] = '{16'hF000, 4'h0, 1'b0, 3, 8'h01};  // HLT

        rst_n = 1'b1;
        for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
        #3;
        do_reset(8'h11, 8'h22, 8'h33, 8'h44);
        check("reset pc/flags/halted/rf_we", {pc, flag_z, flag_n, flag_c, flag_v, halted, rf_we}, 32'h0);
        check("reset decode outputs", {wb_sel, alu_sel, rf_ra, rf_rb, rf_wa, imm}, 32'h0);
`ifdef ALU_CTRL_RETIRE_CNT_EN
        check("reset retired", retired, 32'h0);
`endif

        // Table: decode fields in DECODE, cycles to reach HALT, final pc.
        for (int v = 0; v < 10; v++) begin
            for (int a = 0; a < 256; a++) mem[a] = 16'hF000;
            mem[0] = vecs[v].ins;
            do_reset(8'h11, 8'h22, 8'h33, 8'h44);
            n = 0;
            while (halted !== 1'b1 && n < 20) begin
                @(posedge clk);
                @(negedge clk);
                n++;
                if (n == 1)
                    check($sformatf("vec%0d decode", v), {alu_sel, wb_sel, rf_ra, rf_rb, rf_wa, imm},
                          {vecs[v].alu_sel, vecs[v].wb_sel, vecs[v].ins[11:10], vecs[v].ins[9:8],
                           vecs[v].ins[11:10], vecs[v].ins[7:0]});
            end
            check($sformatf("vec%0d cycles to halt", v), n, vecs[v].cyc);
            check($sformatf("vec%0d pc", v), pc, vecs[v].pc);
        end

        // Sequence: LDI/ADD overflow, CMP+JZ taken, JC not taken, JMP to 0xFF and wrap.
        for (int a = 0; a < 256; a++) mem[a] = 16'hE000;
        mem[8'h00] = 16'hA47F;  // LDI r1,0x7F
        mem[8'h01] = 16'h0600;  // ADD r1,r2
        mem[8'h02] = 16'h9000;  // CMP r0,r0
        mem[8'h03] = 16'hC040;  // JZ 0x40
        mem[8'h40] = 16'hAC12;  // LDI r3,0x12
        mem[8'h41] = 16'hD010;  // JC 0x10
        mem[8'h42] = 16'hB0FF;  // JMP 0xFF
        mem[8'hFF] = 16'hE000;  // NOP
        do_reset(8'h00, 8'h00, 8'h01, 8'h00);
        run_instr("ldi r1");
        run_instr("add r1,r2");
        check("add flag_n", flag_n, 1'b1);
        check("add flag_v", flag_v, 1'b1);
        check("add result r1", rf[1], 8'h80);
        run_instr("cmp r0,r0");
        check("cmp flag_z", flag_z, 1'b1);
        run_instr("jz 0x40");
        check("jz taken pc", pc, 8'h40);
        run_instr("ldi r3");
        run_instr("jc 0x10");
        check("jc not taken pc", pc, 8'h42);
        check("flag_z kept across ldi", flag_z, 1'b1);
        run_instr("jmp 0xff");
        run_instr("nop at 0xff");
        check("pc wrap", pc, 8'h00);

        // Reset asserted mid-EXECUTE of the LDI at 0x00.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid-exec reset pc/flags/halted/rf_we", {pc, flag_z, flag_n, flag_c, flag_v, halted, rf_we}, 32'h0);
        check("mid-exec reset ir fields", {wb_sel, imm, rf_ra}, 32'h0);
        check("mid-exec reset no write", {rf[0], rf[1], rf[2], rf[3]}, {m_rf[0], m_rf[1], m_rf[2], m_rf[3]});
        @(negedge clk);
        do_reset(m_rf[0], m_rf[1], m_rf[2], m_rf[3]);
        run_instr("first fetch after reset");

        // HLT at 0x05, then 20 idle cycles.
        for (int a = 0; a < 256; a++) mem[a] = 16'hE000;
        mem[0] = 16'hA8A5;  // LDI r2,0xA5
        mem[1] = 16'h1A00;  // SUB r2,r2
        mem[2] = 16'hE000;  // NOP
        mem[3] = 16'h5400;  // NOT r1
        mem[4] = 16'h8C00;  // INC r3
        mem[5] = 16'hF000;  // HLT
        mem[6] = 16'hA4FF;  // LDI r1,0xFF (must never run)
        do_reset(8'h01, 8'h02, 8'h03, 8'h7F);
        for (int i = 0; i < 6; i++) run_instr($sformatf("halt prog %0d", i));
        bad_pc = 0; bad_we = 0; bad_halt = 0;
        for (int i = 0; i < 20; i++) begin
            if (pc !== 8'h06) bad_pc++;
            if (rf_we !== 1'b0) bad_we++;
            if (halted !== 1'b1) bad_halt++;
            @(posedge clk);
            @(negedge clk);
        end
        check("halt pc frozen cycles", bad_pc, 0);
        check("halt rf_we cycles", bad_we, 0);
        check("halt halted low cycles", bad_halt, 0);
        check("halt regs untouched", {rf[0], rf[1], rf[2], rf[3]}, {m_rf[0], m_rf[1], m_rf[2], m_rf[3]});
`ifdef ALU_CTRL_RETIRE_CNT_EN
        check("halt retired count", retired, 32'd6);
`endif

        // Randomized programs against the reference model.
        for (int p = 0; p < 3; p++) begin
            for (int a = 0; a < 256; a++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'hE;
                r = $urandom();
                mem[a] = {op, r[11:0]};
            end
            r = $urandom();
            do_reset(r[7:0], r[15:8], r[23:16], r[31:24]);
            for (int i = 0; i < 120; i++) begin
                if (m_halted) break;
                run_instr($sformatf("rand%0d.%0d", p, i));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
